// File: rtl/vga_pkg.sv
// Shared timing constants and phase enums for the 640x480 @ 60 Hz raster.
// The colour width is kept here so the pixel generators and the timing
// generator agree on one definition.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam int VGA_CLK_DIV  = 1;

   localparam int COLOR_W      = 6;

   typedef enum logic [1:0] {
      H_ACT,
      H_FP,
      H_SYN,
      H_BP
   } h_phase_t;

   typedef enum logic [1:0] {
      V_ACT,
      V_FP,
      V_SYN,
      V_BP
   } v_phase_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: produces a one-clock tick every CLK_DIV system clocks.
// With CLK_DIV = 1 the tick is permanently high and clk is the pixel clock.
module pix_tick_gen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   // Divider counts 0..CLK_DIV-1 and wraps, restarting from 0 on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: walks col/row over the full frame, tracks the
// horizontal and vertical phases with small FSMs, and registers every output
// on the same edge so that coordinates, valid and syncs describe one pixel.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = VGA_CLK_DIV,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FRONT  = VGA_H_FRONT,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BACK   = VGA_H_BACK,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FRONT  = VGA_V_FRONT,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BACK   = VGA_V_BACK
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] col,
   output logic [9:0] row,
   output logic       valid,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam logic [9:0] H_FP_START  = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYN_START = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] H_BP_START  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST      = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);

   localparam logic [9:0] V_FP_START  = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYN_START = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] V_BP_START  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST      = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

   logic       tick;
   logic       line_end;
   logic [9:0] col_nxt;
   logic [9:0] row_nxt;
   h_phase_t   h_state;
   h_phase_t   h_nxt;
   v_phase_t   v_state;
   v_phase_t   v_nxt;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Next position and next phase, evaluated as if this edge were a tick;
   // the registered outputs below are decoded from these values.
   always_comb begin
      line_end = (col == H_LAST);
      col_nxt  = line_end ? '0 : col + 10'd1;
      row_nxt  = row;
      h_nxt    = h_state;
      v_nxt    = v_state;

      case (h_state)
         H_ACT:   if (col_nxt == H_FP_START)  h_nxt = H_FP;
         H_FP:    if (col_nxt == H_SYN_START) h_nxt = H_SYN;
         H_SYN:   if (col_nxt == H_BP_START)  h_nxt = H_BP;
         default: if (col_nxt == '0)          h_nxt = H_ACT;
      endcase

      if (line_end) begin
         row_nxt = (row == V_LAST) ? '0 : row + 10'd1;
         case (v_state)
            V_ACT:   if (row_nxt == V_FP_START)  v_nxt = V_FP;
            V_FP:    if (row_nxt == V_SYN_START) v_nxt = V_SYN;
            V_SYN:   if (row_nxt == V_BP_START)  v_nxt = V_BP;
            default: if (row_nxt == '0)          v_nxt = V_ACT;
         endcase
      end
   end

   // Position, phase FSMs and decoded outputs all advance together on a tick;
   // reset parks everything on the last pixel so the first tick shows (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col         <= H_LAST;
         row         <= V_LAST;
         h_state     <= H_BP;
         v_state     <= V_BP;
         valid       <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else if (tick) begin
         col         <= col_nxt;
         row         <= row_nxt;
         h_state     <= h_nxt;
         v_state     <= v_nxt;
         valid       <= (h_nxt == H_ACT) && (v_nxt == V_ACT);
         hsync       <= (h_nxt != H_SYN);
         vsync       <= (v_nxt != V_SYN);
         frame_start <= (col_nxt == '0) && (row_nxt == '0);
         if ((col_nxt == '0) && (row_nxt == '0)) begin
            frame_count <= frame_count + 8'd1;
         end
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Three instances share clock and reset:
// default 640x480 timing at CLK_DIV 1, a small raster at CLK_DIV 2, and the
// tiny 4/1/1/1 x 3/1/1/1 raster used to wrap the frame counter. Stimulus
// pushes expected outputs into a queue; a negedge monitor pops and compares.
module tb_vga_timing_gen;

   typedef struct {
      int         at;
      int         inst;
      int         tag;
      logic [9:0] col;
      logic [9:0] row;
      logic       valid;
      logic       hsync;
      logic       vsync;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   typedef struct {
      int         inst;
      int         k;
      logic [9:0] col;
      logic [9:0] row;
      logic       valid;
      logic       hsync;
      logic       vsync;
      logic       fs;
      logic [7:0] fc;
   } dir_t;

   logic       clk;
   logic       rst_n;
   logic [9:0] colv [3];
   logic [9:0] rowv [3];
   logic       validv [3];
   logic       hsyncv [3];
   logic       vsyncv [3];
   logic       fsv [3];
   logic [7:0] fcv [3];

   exp_t sb [$];
   dir_t dirs [$];
   int   negCount = 0;
   int   k = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t monE;

   vga_timing_gen u_dut_a (
      .clk (clk), .rst_n (rst_n),
      .col (colv[0]), .row (rowv[0]), .valid (validv[0]),
      .hsync (hsyncv[0]), .vsync (vsyncv[0]),
      .frame_start (fsv[0]), .frame_count (fcv[0])
   );

   vga_timing_gen #(
      .CLK_DIV (2),
      .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_ACTIVE (5), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
   ) u_dut_b (
      .clk (clk), .rst_n (rst_n),
      .col (colv[1]), .row (rowv[1]), .valid (validv[1]),
      .hsync (hsyncv[1]), .vsync (vsyncv[1]),
      .frame_start (fsv[1]), .frame_count (fcv[1])
   );

   vga_timing_gen #(
      .CLK_DIV (1),
      .H_ACTIVE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
      .V_ACTIVE (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
   ) u_dut_c (
      .clk (clk), .rst_n (rst_n),
      .col (colv[2]), .row (rowv[2]), .valid (validv[2]),
      .hsync (hsyncv[2]), .vsync (vsyncv[2]),
      .frame_start (fsv[2]), .frame_count (fcv[2])
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs k edges after reset release, from frame arithmetic.
   function automatic exp_t model(input int inst, input int kk, input bit inRst);
      exp_t e;
      int ha, hf, hs, hb, va, vf, vs, vb, d;
      int ht, vt, fr, n, p, c, r;
      case (inst)
         0:       begin ha = 640; hf = 16; hs = 96; hb = 48; va = 480; vf = 10; vs = 2; vb = 33; d = 1; end
         1:       begin ha = 8;   hf = 2;  hs = 3;  hb = 2;  va = 5;   vf = 1;  vs = 2; vb = 1;  d = 2; end
         default: begin ha = 4;   hf = 1;  hs = 1;  hb = 1;  va = 3;   vf = 1;  vs = 1; vb = 1;  d = 1; end
      endcase
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      fr = ht * vt;
      n  = inRst ? 0 : kk / d;
      e.at   = negCount;
      e.inst = inst;
      e.tag  = inRst ? 2 : 0;
      if (n == 0) begin
         c = ht - 1;
         r = vt - 1;
         e.fs = 1'b0;
         e.fc = 8'd0;
      end else begin
         p = (n - 1) % fr;
         c = p % ht;
         r = p / ht;
         e.fs = (p == 0) && (kk % d == 0);
         e.fc = 8'(((n - 1) / fr + 1) % 256);
      end
      e.col   = 10'(c);
      e.row   = 10'(r);
      e.valid = (c < ha) && (r < va);
      e.hsync = !((c >= ha + hf) && (c < ha + hf + hs));
      e.vsync = !((r >= va + vf) && (r < va + vf + vs));
      return e;
   endfunction

   function automatic string tagName(input int tag);
      if (tag == 1) return "directed";
      if (tag == 2) return "reset";
      return "scan";
   endfunction

   task automatic addDir(input int inst, input int kk, input int c, input int r,
                         input bit v, input bit hs, input bit vs, input bit fs, input int fc);
      dir_t d;
      d.inst = inst; d.k = kk; d.col = 10'(c); d.row = 10'(r);
      d.valid = v; d.hsync = hs; d.vsync = vs; d.fs = fs; d.fc = 8'(fc);
      dirs.push_back(d);
   endtask

   // Queue the expectation for the coming negedge, model plus any directed vector.
   task automatic pushAll();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(model(i, k, !rst_n));
      end
      if (rst_n) begin
         foreach (dirs[j]) begin
            if (dirs[j].k == k) begin
               e.at = negCount; e.inst = dirs[j].inst; e.tag = 1;
               e.col = dirs[j].col; e.row = dirs[j].row; e.valid = dirs[j].valid;
               e.hsync = dirs[j].hsync; e.vsync = dirs[j].vsync;
               e.fs = dirs[j].fs; e.fc = dirs[j].fc;
               sb.push_back(e);
            end
         end
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         if (rst_n) k++;
         #1;
         pushAll();
      end
   endtask

   // Reset is asserted between edges so the next sample proves it is asynchronous.
   task automatic applyReset(input int hold);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      k = 0;
      pushAll();
      repeat (hold) begin
         @(posedge clk);
         #1;
         pushAll();
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pushAll();
   endtask

   task automatic checkOutput(input exp_t e);
      int i;
      i = e.inst;
      checks++;
      if (colv[i] !== e.col || rowv[i] !== e.row || validv[i] !== e.valid ||
          hsyncv[i] !== e.hsync || vsyncv[i] !== e.vsync ||
          fsv[i] !== e.fs || fcv[i] !== e.fc) begin
         failures++;
         $display("[TB] FAIL %s inst=%0d sample=%0d got col=%0d row=%0d valid=%b hsync=%b vsync=%b fs=%b fc=%0d expected col=%0d row=%0d valid=%b hsync=%b vsync=%b fs=%b fc=%0d",
                  tagName(e.tag), i, e.at, colv[i], rowv[i], validv[i], hsyncv[i],
                  vsyncv[i], fsv[i], fcv[i], e.col, e.row, e.valid, e.hsync,
                  e.vsync, e.fs, e.fc);
      end
   endtask

   // Monitor: compare every expectation queued for this negedge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].at <= negCount) begin
         monE = sb.pop_front();
         checkOutput(monE);
      end
      negCount++;
   end

   initial begin
      rst_n = 1'b1;

      // default timing, CLK_DIV 1
      addDir(0, 1,    0,   0, 1, 1, 1, 1, 1);
      addDir(0, 2,    1,   0, 1, 1, 1, 0, 1);
      addDir(0, 640,  639, 0, 1, 1, 1, 0, 1);
      addDir(0, 641,  640, 0, 0, 1, 1, 0, 1);
      addDir(0, 656,  655, 0, 0, 1, 1, 0, 1);
      addDir(0, 657,  656, 0, 0, 0, 1, 0, 1);
      addDir(0, 752,  751, 0, 0, 0, 1, 0, 1);
      addDir(0, 753,  752, 0, 0, 1, 1, 0, 1);
      addDir(0, 800,  799, 0, 0, 1, 1, 0, 1);
      addDir(0, 801,  0,   1, 1, 1, 1, 0, 1);
      addDir(0, 1900, 299, 2, 1, 1, 1, 0, 1);
      // small raster, CLK_DIV 2
      addDir(1, 1,   14, 8, 0, 1, 1, 0, 0);
      addDir(1, 2,   0,  0, 1, 1, 1, 1, 1);
      addDir(1, 3,   0,  0, 1, 1, 1, 0, 1);
      addDir(1, 4,   1,  0, 1, 1, 1, 0, 1);
      addDir(1, 272, 0,  0, 1, 1, 1, 1, 2);
      addDir(1, 273, 0,  0, 1, 1, 1, 0, 2);
      // tiny raster, counter wrap
      addDir(2, 1,     0, 0, 1, 1, 1, 1, 1);
      addDir(2, 5,     4, 0, 0, 1, 1, 0, 1);
      addDir(2, 6,     5, 0, 0, 0, 1, 0, 1);
      addDir(2, 7,     6, 0, 0, 1, 1, 0, 1);
      addDir(2, 8,     0, 1, 1, 1, 1, 0, 1);
      addDir(2, 29,    0, 4, 0, 1, 0, 0, 1);
      addDir(2, 36,    0, 5, 0, 1, 1, 0, 1);
      addDir(2, 43,    0, 0, 1, 1, 1, 1, 2);
      addDir(2, 10710, 6, 5, 0, 1, 1, 0, 255);
      addDir(2, 10711, 0, 0, 1, 1, 1, 1, 0);
      addDir(2, 10712, 1, 0, 1, 1, 1, 0, 0);

      applyReset(3);
      applyStimulus(1900);
      applyReset(3);
      applyStimulus(10760);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain got pending=%0d expected pending=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
